led_bcd_display: RTL and testbench

Output stage that sits directly downstream of the processor core's 8-bit LED result register. It captures an 8-bit value on a strobe and converts it to three BCD digits with an iterative shift-add-3 (double-dabble) FSM. It then drives a time-multiplexed 3-digit seven-segment display, which gives board-level readable decimal output of program results.

---
 rtl/led_bcd_display_pkg.sv | 27 ++
 rtl/led_bcd_display_seg7_decoder.sv | 29 ++
 rtl/led_bcd_display.sv | 135 +++++++++++++
 tb/tb_led_bcd_display.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_bcd_display_pkg.sv
// Shared definitions for led_bcd_display: FSM states, segment codes, BCD helper.
package led_bcd_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_LOAD
    } state_t;

    // Segment codes are {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/led_bcd_display_seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder with blanking.
module seg7_decoder
    import led_bcd_display_pkg::*;
(
    input  logic [3:0] iDigit,
    input  logic       iBlank,
    output logic [6:0] oSeg
);

    always_comb begin
        oSeg = SEG_BLANK;
        if (!iBlank) begin
            case (iDigit)
                4'd0:    oSeg = SEG_0;
                4'd1:    oSeg = SEG_1;
                4'd2:    oSeg = SEG_2;
                4'd3:    oSeg = SEG_3;
                4'd4:    oSeg = SEG_4;
                4'd5:    oSeg = SEG_5;
                4'd6:    oSeg = SEG_6;
                4'd7:    oSeg = SEG_7;
                4'd8:    oSeg = SEG_8;
                4'd9:    oSeg = SEG_9;
                default: oSeg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/led_bcd_display.sv
// 8-bit value to 3-digit multiplexed seven-segment display via double-dabble FSM.
// Optional leading-zero blanking: define LEDDISP_BLANK_LEADING_ZERO_EN.
module led_bcd_display
    import led_bcd_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned REFRESH_W   = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iValid,
    output logic       oBusy,
    output logic       oDone,
    output logic [6:0] oSegments,
    output logic [2:0] oAnode
);

    state_t                 r_state;
    logic [7:0]             r_shift;
    logic [11:0]            r_bcd;
    logic [2:0]             r_iter;
    logic                   r_done;
    logic [3:0]             r_dig_u, r_dig_t, r_dig_h;
    logic [REFRESH_W-1:0]   r_refresh;
    logic [1:0]             r_idx;
    logic [2:0]             r_anode;
    logic [6:0]             r_seg;

    logic [11:0]            w_adj;
    logic [3:0]             w_digit;
    logic                   w_blank;
    logic                   w_blank_t, w_blank_h;
    logic [2:0]             w_anode;
    logic [6:0]             w_seg;

    assign w_adj = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_bcd   <= '0;
            r_iter  <= '0;
            r_done  <= 1'b0;
            r_dig_u <= '0;
            r_dig_t <= '0;
            r_dig_h <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (iValid) begin
                        r_shift <= iData;
                        r_bcd   <= '0;
                        r_iter  <= '0;
                        r_state <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    // Hundreds never exceeds 2, so the adjusted MSB shifted out is always 0
                    r_bcd   <= (w_adj << 1) | 12'(r_shift[7]);
                    r_shift <= {r_shift[6:0], 1'b0};
                    r_iter  <= r_iter + 3'd1;
                    if (r_iter == 3'd7) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_dig_h <= r_bcd[11:8];
                    r_dig_t <= r_bcd[7:4];
                    r_dig_u <= r_bcd[3:0];
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_refresh <= '0;
            r_idx     <= '0;
            r_anode   <= 3'b110;
            r_seg     <= SEG_0;
        end else begin
            if (r_refresh == REFRESH_W'(REFRESH_DIV - 1)) begin
                r_refresh <= '0;
                r_idx     <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end
            r_anode <= w_anode;
            r_seg   <= w_seg;
        end
    end

`ifdef LEDDISP_BLANK_LEADING_ZERO_EN
    assign w_blank_h = (r_dig_h == 4'd0);
    assign w_blank_t = (r_dig_h == 4'd0) && (r_dig_t == 4'd0);
`else
    assign w_blank_h = 1'b0;
    assign w_blank_t = 1'b0;
`endif

    always_comb begin
        w_digit = r_dig_u;
        w_blank = 1'b0;
        w_anode = 3'b110;
        case (r_idx)
            2'd1: begin
                w_digit = r_dig_t;
                w_blank = w_blank_t;
                w_anode = 3'b101;
            end
            2'd2: begin
                w_digit = r_dig_h;
                w_blank = w_blank_h;
                w_anode = 3'b011;
            end
            default: ;
        endcase
    end

    seg7_decoder u_dec (
        .iDigit (w_digit),
        .iBlank (w_blank),
        .oSeg   (w_seg)
    );

    assign oBusy     = (r_state != ST_IDLE);
    assign oDone     = r_done;
    assign oSegments = r_seg;
    assign oAnode    = r_anode;

endmodule

// File: tb/tb_led_bcd_display.sv
// Self-checking bench for led_bcd_display with a decimal-arithmetic reference model.
module tb_led_bcd_display;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] iData;
    logic       iValid;
    logic       oBusy, oDone;
    logic [6:0] oSegments;
    logic [2:0] oAnode;

    int tests = 0;
    int fails = 0;
    int cyc;
    int disp_val = 0;
    logic [6:0] seg_tab [0:9];

    led_bcd_display #(.REFRESH_DIV(4), .REFRESH_W(16)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .iData     (iData),
        .iValid    (iValid),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oSegments (oSegments),
        .oAnode    (oAnode)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [6:0] exp_seg(input int idx);
        int h, t, u;
        h = disp_val / 100;
        t = (disp_val / 10) % 10;
        u = disp_val % 10;
`ifdef LEDDISP_BLANK_LEADING_ZERO_EN
        if (idx == 2 && h == 0) return 7'b1111111;
        if (idx == 1 && h == 0 && t == 0) return 7'b1111111;
`endif
        if (idx == 2) return seg_tab[h];
        if (idx == 1) return seg_tab[t];
        return seg_tab[u];
    endfunction

    task automatic check_scan(input string tag);
        int idx;
        logic [2:0] ea;
        logic [6:0] es;
        for (int k = 0; k < 14; k++) begin
            idx = (cyc == 0) ? 0 : ((cyc - 1) / 4) % 3;
            ea = 3'b111;
            ea[idx] = 1'b0;
            es = exp_seg(idx);
            tests++;
            if (oAnode !== ea) begin
                fails++;
                $display("FAIL %s anode cyc=%0d got=%b exp=%b", tag, cyc, oAnode, ea);
            end
            tests++;
            if (oSegments !== es) begin
                fails++;
                $display("FAIL %s seg idx=%0d val=%0d got=%b exp=%b", tag, idx, disp_val, oSegments, es);
            end
            @(negedge Clock);
        end
    endtask

    task automatic run_conversion(input logic [7:0] v, input string tag);
        @(negedge Clock);
        iData  = v;
        iValid = 1'b1;
        @(negedge Clock);
        iValid = 1'b0;
        iData  = 8'($urandom);
        for (int k = 0; k < 9; k++) begin
            tests++;
            if (oBusy !== 1'b1 || oDone !== 1'b0) begin
                fails++;
                $display("FAIL %s busy k=%0d busy=%b done=%b exp busy=1 done=0", tag, k, oBusy, oDone);
            end
            @(negedge Clock);
        end
        tests++;
        if (oBusy !== 1'b0 || oDone !== 1'b1) begin
            fails++;
            $display("FAIL %s done_pulse busy=%b done=%b exp busy=0 done=1", tag, oBusy, oDone);
        end
        @(negedge Clock);
        tests++;
        if (oDone !== 1'b0) begin
            fails++;
            $display("FAIL %s done_width done=%b exp=0", tag, oDone);
        end
        disp_val = int'(v);
        check_scan(tag);
    endtask

    task automatic test_reset();
        tests++;
        if (oAnode !== 3'b110 || oSegments !== 7'b1000000 || oBusy !== 1'b0 || oDone !== 1'b0) begin
            fails++;
            $display("FAIL reset_state anode=%b seg=%b busy=%b done=%b exp 110 1000000 0 0",
                     oAnode, oSegments, oBusy, oDone);
        end
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        disp_val = 0;
        check_scan("reset_scan");
    endtask

    task automatic test_convert();
        logic [7:0] dir [0:3];
        dir[0] = 8'd255; dir[1] = 8'd107; dir[2] = 8'd7; dir[3] = 8'd0;
        for (int i = 0; i < 4; i++) run_conversion(dir[i], "directed");
        for (int i = 0; i < 8; i++) run_conversion(8'($urandom_range(0, 255)), "random");
    endtask

    task automatic test_back_to_back();
        bit seen;
        @(negedge Clock);
        iData = 8'd42; iValid = 1'b1;
        @(negedge Clock);
        iValid = 1'b0;
        repeat (2) @(negedge Clock);
        iData = 8'd99; iValid = 1'b1;
        @(negedge Clock);
        iValid = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (oDone === 1'b1) seen = 1;
            else @(negedge Clock);
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL b2b_done timeout got=0 exp=1");
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            tests++;
            if (oBusy !== 1'b0) begin
                fails++;
                $display("FAIL b2b_ignored busy=%b exp=0", oBusy);
            end
        end
        disp_val = 42;
        check_scan("b2b");
    endtask

    task automatic test_held_valid();
        bit seen;
        @(negedge Clock);
        iData = 8'd99; iValid = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge Clock);
            if (oDone === 1'b1) seen = 1;
        end
        tests++;
        if (!seen || oBusy !== 1'b0) begin
            fails++;
            $display("FAIL held_first seen=%0d busy=%b exp seen=1 busy=0", seen, oBusy);
        end
        @(negedge Clock);
        iValid = 1'b0;
        tests++;
        if (oBusy !== 1'b1) begin
            fails++;
            $display("FAIL held_recapture busy=%b exp=1", oBusy);
        end
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge Clock);
            if (oDone === 1'b1) seen = 1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL held_second timeout got=0 exp=1");
        end
        @(negedge Clock);
        disp_val = 99;
        check_scan("held");
    endtask

    task automatic test_reset_mid_conversion();
        @(negedge Clock);
        iData = 8'd200; iValid = 1'b1;
        @(negedge Clock);
        iValid = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        #1;
        tests++;
        if (oAnode !== 3'b110 || oSegments !== 7'b1000000 || oBusy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_state anode=%b seg=%b busy=%b exp 110 1000000 0",
                     oAnode, oSegments, oBusy);
        end
        @(negedge Clock);
        Reset = 1'b1;
        disp_val = 0;
        for (int k = 0; k < 12; k++) begin
            tests++;
            if (oDone !== 1'b0 || oBusy !== 1'b0) begin
                fails++;
                $display("FAIL midreset_abort done=%b busy=%b exp 0 0", oDone, oBusy);
            end
            @(negedge Clock);
        end
        check_scan("midreset_scan");
        run_conversion(8'd200, "after_reset");
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        Reset  = 1'b0;
        iData  = 8'd0;
        iValid = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        test_reset();
        test_convert();
        test_back_to_back();
        test_held_valid();
        test_reset_mid_conversion();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
